// File: rtl/val_ready_tx_ser.sv
// Purpose: serializes one NBEATS*DW word into NBEATS valid/ready beats, flagging the final beat with last_o.
// Latency: first beat is valid 1 cycle after load accept; a load taken on the last beat follows with no bubble.
// Backpressure: ready_i low holds valid_o/data_o/last_o stable; load_ready_o stays low until the last beat transfers.
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   load_valid_i / load_ready_o / load_data_i  - upstream word handshake, beat 0 = bits [DW-1:0]
//   valid_o / ready_i / data_o / last_o        - downstream beat handshake
//   busy_o                                     - high while a word is being sent
//   stall_cnt_o                                - saturating valid&&!ready cycle count, present only
//                                                when VR_TX_STALL_CNT_EN is defined
module val_ready_tx_ser #(
    parameter int DW     = 8,
    parameter int NBEATS = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_valid_i,
    output logic                 load_ready_o,
    input  logic [DW*NBEATS-1:0] load_data_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DW-1:0]        data_o,
    output logic                 last_o,
    output logic                 busy_o
`ifdef VR_TX_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt_o
`endif
);

    localparam int CW = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NBEATS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [DW*NBEATS-1:0]   shreg_q;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_nxt;
    logic                   last_q;
    logic                   xfer;
    logic                   accept;

    // The current beat always sits in the low DW bits of the shift register,
    // so data_o is a pure register output and simply holds once the burst ends.
    assign data_o  = shreg_q[DW-1:0];
    assign last_o  = last_q;
    assign valid_o = (state_q == SEND);
    assign busy_o  = (state_q == SEND);
    assign cnt_nxt = cnt_q + CW'(1);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        // last_q is only ever set in SEND, so this is the only ready_i -> output path.
        load_ready_o = (state_q == IDLE) || (last_q && ready_i);
        xfer         = valid_o && ready_i;
        accept       = load_valid_i && load_ready_o;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer && last_q && !accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else if (accept) begin
            // Also covers the back-to-back case: the new word replaces the final beat.
            shreg_q <= load_data_i;
            cnt_q   <= '0;
            last_q  <= (NBEATS == 1);
        end else if (xfer) begin
            if (last_q) begin
                last_q <= 1'b0;
            end else begin
                shreg_q <= shreg_q >> DW;
                cnt_q   <= cnt_nxt;
                last_q  <= (cnt_nxt == LAST_CNT);
            end
        end
    end

`ifdef VR_TX_STALL_CNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (accept) begin
            stall_cnt_o <= '0;
        end else if (valid_o && !ready_i && (stall_cnt_o != 16'hFFFF)) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_val_ready_tx_ser.sv
module tb_val_ready_tx_ser;

    localparam int DW     = 8;
    localparam int NBEATS = 4;

    logic                 clk_i;
    logic                 rst_i;
    logic                 load_valid_i;
    logic                 load_ready_o;
    logic [DW*NBEATS-1:0] load_data_i;
    logic                 valid_o;
    logic                 ready_i;
    logic [DW-1:0]        data_o;
    logic                 last_o;
    logic                 busy_o;
`ifdef VR_TX_STALL_CNT_EN
    logic [15:0]          stall_cnt_o;
`endif

    val_ready_tx_ser #(.DW(DW), .NBEATS(NBEATS)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .load_data_i  (load_data_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .data_o       (data_o),
        .last_o       (last_o),
        .busy_o       (busy_o)
`ifdef VR_TX_STALL_CNT_EN
        ,
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model: a queue of beats still owed downstream. The front entry
    // is the beat currently presented; an empty queue means nothing is offered.
    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    beat_t         q[$];
    logic [DW-1:0] hold_d;
    int            m_stall;
    int            checks;
    int            errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare all outputs against the model, given the ready_i currently driven.
    task automatic check_outputs();
        logic exp_lr;
        exp_lr = (q.size() == 0) || (q.size() == 1 && ready_i);
        if (q.size() > 0) hold_d = q[0].d;
        chk("valid_o", valid_o, (q.size() > 0));
        chk("busy_o", busy_o, (q.size() > 0));
        chk("load_ready_o", load_ready_o, exp_lr);
        chk("data_o", data_o, hold_d);
        chk("last_o", last_o, (q.size() > 0) ? q[0].l : 1'b0);
`ifdef VR_TX_STALL_CNT_EN
        chk("stall_cnt_o", stall_cnt_o, m_stall);
`endif
    endtask

    task automatic model_edge(input logic lv, input logic [31:0] ld, input logic rdy);
        logic exp_lr;
        exp_lr = (q.size() == 0) || (q.size() == 1 && rdy);
        if (q.size() > 0) begin
            if (rdy) void'(q.pop_front());
            else if (m_stall < 32'hFFFF) m_stall++;
        end
        if (lv && exp_lr) begin
            m_stall = 0;
            for (int i = 0; i < NBEATS; i++) begin
                beat_t b;
                b.d = ld[i*DW +: DW];
                b.l = (i == NBEATS - 1);
                q.push_back(b);
            end
        end
    endtask

    // One cycle: drive at the falling edge, check 1ns later, advance model at the rising edge.
    task automatic step(input logic lv, input logic [31:0] ld, input logic rdy);
        load_valid_i = lv;
        load_data_i  = ld;
        ready_i      = rdy;
        #1;
        check_outputs();
        @(posedge clk_i);
        model_edge(lv, ld, rdy);
        @(negedge clk_i);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        hold_d       = '0;
        m_stall      = 0;
        rst_i        = 1'b0;
        load_valid_i = 1'b1;          // loads must be ignored while in reset
        load_data_i  = 32'hFEEDF00D;
        ready_i      = 1'b1;

        // Reset for two cycles
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_last", last_o, 1'b0);
        chk("rst_data", data_o, 8'h00);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_load_ready", load_ready_o, 1'b1);
`ifdef VR_TX_STALL_CNT_EN
        chk("rst_stall", stall_cnt_o, 16'h0000);
`endif
        load_valid_i = 1'b0;
        rst_i        = 1'b1;
        step(0, 32'h0, 1);

        // Plain burst with ready held high
        step(1, 32'h44332211, 1);
        repeat (4) step(0, 32'h0, 1);
        chk("burst_idle_data", data_o, 8'h44);
        step(0, 32'h0, 1);

        // Backpressure on beat 0x22 for three cycles
        step(1, 32'h44332211, 1);
        step(0, 32'h0, 1);
        repeat (3) step(0, 32'h0, 0);
        chk("stall_hold_data", data_o, 8'h22);
        chk("stall_hold_valid", valid_o, 1'b1);
`ifdef VR_TX_STALL_CNT_EN
        chk("stall_cnt_3", stall_cnt_o, 16'd3);
`endif
        repeat (4) step(0, 32'h0, 1);

        // Load offered mid-burst is refused; load on the last beat goes back-to-back
        step(1, 32'h44332211, 1);
        step(0, 32'h0, 1);
        step(1, 32'h55667788, 1);
        step(0, 32'h0, 1);
        step(1, 32'hDDCCBBAA, 1);
        chk("b2b_first", data_o, 8'hAA);
        chk("b2b_valid", valid_o, 1'b1);
        repeat (4) step(0, 32'h0, 1);

        // Reset in the middle of a burst, after beat 0x22 has transferred
        step(1, 32'h44332211, 1);
        step(0, 32'h0, 1);
        step(0, 32'h0, 1);
        rst_i = 1'b0;
        #1;
        chk("midrst_valid", valid_o, 1'b0);
        chk("midrst_last", last_o, 1'b0);
        chk("midrst_busy", busy_o, 1'b0);
        q.delete();
        hold_d  = '0;
        m_stall = 0;
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (3) step(0, 32'h0, 1);

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            step(($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 3) != 0));
        end
        repeat (6) step(0, 32'h0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
